shift_reg_piso: RTL and testbench

Parameterised parallel-in serial-out shift register. It captures a WIDTH-bit word on a load strobe, then shifts it out one bit per enabled clock, MSB first. It sits at the boundary between a parallel datapath and a single-wire serial link or test/monitor output. It is purely synchronous apart from the asynchronous reset.

---
 rtl/shift_reg_piso.sv | 38 +++
 tb/tb_shift_reg_piso.sv | 126 ++++++++++++
 2 files changed

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register: a load captures a word, and each enabled shift emits it MSB first.
// data_out comes straight from the register MSB. There is no handshake, so the upstream controller counts the shifts.
`timescale 1ns/1ps
module shift_reg_piso #(
  parameter int   WIDTH    = 4,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out
);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;

  // Load beats shift. data_in is only selected when load is high, so an undriven word cannot leak in.
  always_comb begin
    w_sreg_nxt = r_sreg;
    if (load)
      w_sreg_nxt = data_in;
    else if (shift_en)
      w_sreg_nxt = {r_sreg[WIDTH-2:0], FILL_BIT};
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      r_sreg <= '0;
    else
      r_sreg <= w_sreg_nxt;
  end

  assign data_out = r_sreg[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_piso.sv
// Directed bench for shift_reg_piso (WIDTH=4): a reference register predicts data_out after every edge.
`timescale 1ns/1ps
module tb_shift_reg_piso;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] data_in;
  logic             data_out;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] m_sreg;
  logic             exp_q[$];

  shift_reg_piso #(.WIDTH(WIDTH), .FILL_BIT(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, predict, then compare just after the rising edge.
  task automatic cyc(input logic ld, input logic sh, input logic [WIDTH-1:0] din, input string tag);
    logic exp;
    @(negedge clk);
    load     = ld;
    shift_en = sh;
    data_in  = ld ? din : 'x;
    if (ld)
      m_sreg = din;
    else if (sh)
      m_sreg = {m_sreg[WIDTH-2:0], 1'b0};
    exp_q.push_back(m_sreg[WIDTH-1]);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, data_out, exp);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; shift_en = 1'b0; data_in = '0;
    m_sreg = '0;

    // Assert reset between edges. The register is unknown before this, so a 0 here proves the clear is asynchronous.
    #2 rst_n = 1'b1;
    #1 check("rst_async", data_out, 1'b0);
    load = 1'b1; shift_en = 1'b1; data_in = 4'hF;
    @(posedge clk); #1 check("rst_dominates", data_out, 1'b0);
    load = 1'b0; shift_en = 1'b0; data_in = '0;
    #7 check("rst_held", data_out, 1'b0);
    #1 rst_n = 1'b0;
    m_sreg = '0;
    cyc(1'b0, 1'b1, '0, "post_rst_zero");

    // Load then shift past the end.
    cyc(1'b1, 1'b0, 4'b1011, "ld_msb");
    cyc(1'b0, 1'b1, '0, "sh1");
    cyc(1'b0, 1'b1, '0, "sh2");
    cyc(1'b0, 1'b1, '0, "sh3_lsb");
    cyc(1'b0, 1'b1, '0, "sh4_fill");
    cyc(1'b0, 1'b1, '0, "sh5_fill");

    // Hold.
    cyc(1'b1, 1'b0, 4'b1011, "hold_ld");
    cyc(1'b0, 1'b1, '0, "hold_sh1");
    cyc(1'b0, 1'b0, '0, "hold_a");
    cyc(1'b0, 1'b0, '0, "hold_b");
    cyc(1'b0, 1'b1, '0, "hold_res1");
    cyc(1'b0, 1'b1, '0, "hold_res2");
    cyc(1'b0, 1'b1, '0, "hold_res3");

    // Load wins over shift.
    cyc(1'b1, 1'b1, 4'b0110, "prio_ld");
    cyc(1'b0, 1'b1, '0, "prio_sh1");
    cyc(1'b0, 1'b1, '0, "prio_sh2");
    cyc(1'b0, 1'b1, '0, "prio_sh3");

    // Mid-stream reload.
    cyc(1'b1, 1'b0, 4'b1011, "rl_ld1");
    cyc(1'b0, 1'b1, '0, "rl_sh1");
    cyc(1'b0, 1'b1, '0, "rl_sh2");
    cyc(1'b1, 1'b0, 4'b1000, "rl_ld2");
    cyc(1'b0, 1'b1, '0, "rl_sh3");
    cyc(1'b0, 1'b1, '0, "rl_sh4");
    cyc(1'b0, 1'b1, '0, "rl_sh5");

    // Reset pulse in the middle of a shift.
    cyc(1'b1, 1'b0, 4'b1111, "ar_ld");
    cyc(1'b0, 1'b1, '0, "ar_sh1");
    #2 rst_n = 1'b1;
    #1 check("ar_drop", data_out, 1'b0);
    #1 rst_n = 1'b0;
    m_sreg = '0;
    cyc(1'b0, 1'b1, '0, "ar_after1");
    cyc(1'b0, 1'b1, '0, "ar_after2");
    cyc(1'b0, 1'b1, '0, "ar_after3");
    cyc(1'b1, 1'b0, 4'b1000, "ar_reload");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
